// File: rtl/line_render_sched.sv
// Per-scanline render controller: sequences tile then sprite engines, gates their
// linebuffer writes, flips linebuffer halves at a fixed hcount and tracks overruns.
module line_render_sched #(
   parameter int SWAP_HC   = 1590,
   parameter int VACTIVE   = 480,
   parameter int VTOTAL    = 525,
   parameter int DONE_MASK = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        enable,
   input  logic        clear_overrun,
   output logic        tile_start,
   input  logic        tile_done,
   input  logic        tile_wr,
   output logic        sprite_start,
   input  logic        sprite_done,
   input  logic        spr_wr,
   output logic        wren_tile_draw,
   output logic        wren_pixel_draw,
   output logic        switch,
   output logic [9:0]  render_line,
   output logic [31:0] status
);
   localparam int MW = (DONE_MASK > 0) ? $clog2(DONE_MASK + 1) : 1;
   localparam logic [MW-1:0] MASK_INIT     = MW'(DONE_MASK);
   localparam logic [9:0]    LAST_RENDER_V = 10'(VACTIVE - 1);
   localparam logic [9:0]    LAST_V        = 10'(VTOTAL - 1);
   localparam logic [10:0]   SWAP_H        = 11'(SWAP_HC);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TILE   = 2'd1,
      SPRITE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t        state_reg, state_next;
   logic [MW-1:0] mask_reg, mask_next;
   logic          tile_start_reg, tile_start_next;
   logic          sprite_start_reg, sprite_start_next;
   logic          switch_reg, switch_next;
   logic [9:0]    line_reg, line_next;
   logic          sticky_reg, sticky_next;
   logic [7:0]    count_reg, count_next;

   logic render_cond;
   logic swap_point;
   logic overrun;
   logic busy;

   // The last visible line is rendered during the preceding line, so vcount 478 renders 479
   // and the final blanking line renders line 0 of the next frame.
   assign render_cond = (vcount < LAST_RENDER_V) || (vcount == LAST_V);
   assign swap_point  = render_cond && (hcount == SWAP_H);
   assign busy        = (state_reg == TILE) || (state_reg == SPRITE);

   always_comb begin
      state_next        = state_reg;
      mask_next         = mask_reg;
      tile_start_next   = 1'b0;
      sprite_start_next = 1'b0;
      switch_next       = switch_reg;
      line_next         = line_reg;
      sticky_next       = sticky_reg;
      count_next        = count_reg;
      overrun           = 1'b0;

      if (swap_point) begin
         // Overrun judged on the pre-update state, so a done landing on this cycle is late.
         switch_next = ~switch_reg;
         overrun     = (state_reg != DONE) && !((state_reg == IDLE) && !enable);
         state_next  = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if ((hcount == 11'd0) && render_cond && enable) begin
                  tile_start_next = 1'b1;
                  line_next       = (vcount == LAST_V) ? 10'd0 : vcount + 10'd1;
                  mask_next       = MASK_INIT;
                  state_next      = TILE;
               end
            end
            TILE: begin
               if (mask_reg != '0) begin
                  mask_next = mask_reg - MW'(1);
               end else if (tile_done) begin
                  sprite_start_next = 1'b1;
                  mask_next         = MASK_INIT;
                  state_next        = SPRITE;
               end
            end
            SPRITE: begin
               if (mask_reg != '0) begin
                  mask_next = mask_reg - MW'(1);
               end else if (sprite_done) begin
                  state_next = DONE;
               end
            end
            default: begin
            end
         endcase
      end

      if (overrun) begin
         sticky_next = 1'b1;
         count_next  = clear_overrun ? 8'd1 :
                       ((count_reg == 8'hFF) ? 8'hFF : count_reg + 8'd1);
      end else if (clear_overrun) begin
         sticky_next = 1'b0;
         count_next  = 8'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         mask_reg         <= '0;
         tile_start_reg   <= 1'b0;
         sprite_start_reg <= 1'b0;
         switch_reg       <= 1'b0;
         line_reg         <= 10'd0;
         sticky_reg       <= 1'b0;
         count_reg        <= 8'd0;
      end else begin
         state_reg        <= state_next;
         mask_reg         <= mask_next;
         tile_start_reg   <= tile_start_next;
         sprite_start_reg <= sprite_start_next;
         switch_reg       <= switch_next;
         line_reg         <= line_next;
         sticky_reg       <= sticky_next;
         count_reg        <= count_next;
      end
   end

   assign tile_start      = tile_start_reg;
   assign sprite_start    = sprite_start_reg;
   assign switch          = switch_reg;
   assign render_line     = line_reg;
   assign wren_tile_draw  = tile_wr && (state_reg == TILE);
   assign wren_pixel_draw = spr_wr && (state_reg == SPRITE);
   assign status          = {6'd0, line_reg, count_reg, 4'd0, state_reg, sticky_reg, busy};
endmodule

// File: tb/tb_line_render_sched.sv
// Randomised bench for line_render_sched: event-timestamp reference model checked every
// cycle, plus directed scenarios pinned with hand-computed literal expectations.
module tb_line_render_sched;
   localparam int SWAP_HC   = 1590;
   localparam int VACTIVE   = 480;
   localparam int VTOTAL    = 525;
   localparam int DONE_MASK = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] hcount = 11'd5;
   logic [9:0]  vcount = 10'd10;
   logic        enable = 1'b1;
   logic        clear_overrun = 1'b0;
   logic        tile_done = 1'b0;
   logic        tile_wr = 1'b0;
   logic        sprite_done = 1'b0;
   logic        spr_wr = 1'b0;
   logic        tile_start, sprite_start, wren_tile_draw, wren_pixel_draw, switch;
   logic [9:0]  render_line;
   logic [31:0] status;

   int checks = 0;
   int failures = 0;

   line_render_sched #(
      .SWAP_HC(SWAP_HC), .VACTIVE(VACTIVE), .VTOTAL(VTOTAL), .DONE_MASK(DONE_MASK)
   ) dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .enable(enable),
      .clear_overrun(clear_overrun), .tile_start(tile_start), .tile_done(tile_done),
      .tile_wr(tile_wr), .sprite_start(sprite_start), .sprite_done(sprite_done),
      .spr_wr(spr_wr), .wren_tile_draw(wren_tile_draw), .wren_pixel_draw(wren_pixel_draw),
      .switch(switch), .render_line(render_line), .status(status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 tile, 2 sprite, 3 done; m_enter is the cycle
   // index of the first cycle spent in the current phase.
   int m_phase, m_enter, m_line, m_count, cyc;
   bit m_switch, m_sticky, m_ts, m_ss;

   task automatic model_reset();
      m_phase = 0; m_enter = 0; m_line = 0; m_count = 0;
      m_switch = 0; m_sticky = 0; m_ts = 0; m_ss = 0;
   endtask

   task automatic model_step();
      bit rl, ov;
      if (reset) begin
         model_reset();
      end else begin
         rl = (int'(vcount) < VACTIVE - 1) || (int'(vcount) == VTOTAL - 1);
         m_ts = 0; m_ss = 0; ov = 0;
         if (rl && int'(hcount) == SWAP_HC) begin
            m_switch = !m_switch;
            ov = !(m_phase == 3 || (m_phase == 0 && !enable));
            m_phase = 0;
         end else if (m_phase == 0 && hcount == 0 && rl && enable) begin
            m_ts = 1;
            m_line = (int'(vcount) == VTOTAL - 1) ? 0 : int'(vcount) + 1;
            m_phase = 1; m_enter = cyc + 1;
         end else if (m_phase == 1 && cyc - m_enter >= DONE_MASK && tile_done) begin
            m_ss = 1; m_phase = 2; m_enter = cyc + 1;
         end else if (m_phase == 2 && cyc - m_enter >= DONE_MASK && sprite_done) begin
            m_phase = 3;
         end
         if (ov) begin
            m_sticky = 1;
            m_count = clear_overrun ? 1 : ((m_count < 255) ? m_count + 1 : 255);
         end else if (clear_overrun) begin
            m_sticky = 0; m_count = 0;
         end
      end
      cyc++;
   endtask

   task automatic check_all();
      int busy;
      logic [31:0] exp_status;
      busy = (m_phase == 1 || m_phase == 2) ? 1 : 0;
      exp_status = 32'(busy) | (32'(m_sticky) << 1) | (32'(m_phase) << 2)
                 | (32'(m_count) << 8) | (32'(m_line) << 16);
      chk("cmp_tile_start", 32'(tile_start), 32'(m_ts));
      chk("cmp_sprite_start", 32'(sprite_start), 32'(m_ss));
      chk("cmp_switch", 32'(switch), 32'(m_switch));
      chk("cmp_render_line", 32'(render_line), 32'(m_line));
      chk("cmp_status", status, exp_status);
      chk("cmp_wren_tile", 32'(wren_tile_draw), 32'(tile_wr && m_phase == 1));
      chk("cmp_wren_pixel", 32'(wren_pixel_draw), 32'(spr_wr && m_phase == 2));
   endtask

   initial begin
      cyc = 0;
      model_reset();
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         #2;
         if (reset) model_reset();
         check_all();
      end
   end

   task automatic tick(input int h, input int v);
      @(negedge clk);
      hcount = 11'(h);
      vcount = 10'(v);
      @(posedge clk);
      #1;
   endtask

   logic sw_before;

   initial begin
      // 1: first start after reset
      tick(5, 10);
      tick(5, 10);
      reset = 1'b0;
      tick(0, 10);
      chk("t1_tile_start", 32'(tile_start), 32'd1);
      chk("t1_render_line", 32'(render_line), 32'd11);
      chk("t1_state", 32'(status[3:2]), 32'd1);
      // 2: done masked right after start, gating by phase
      tile_done = 1'b1;
      tile_wr = 1'b1;
      tick(1, 10);
      chk("t2_tile_start_off", 32'(tile_start), 32'd0);
      chk("t2_mask1", 32'(sprite_start), 32'd0);
      chk("t2_wren_tile_on", 32'(wren_tile_draw), 32'd1);
      tick(2, 10);
      chk("t2_mask2", 32'(sprite_start), 32'd0);
      tile_done = 1'b0;
      tile_wr = 1'b0;
      for (int h = 3; h < 40; h++) tick(h, 10);
      tile_done = 1'b1;
      tick(40, 10);
      chk("t2_sprite_start", 32'(sprite_start), 32'd1);
      chk("t2_state", 32'(status[3:2]), 32'd2);
      tile_done = 1'b0;
      tile_wr = 1'b1;
      spr_wr = 1'b1;
      #1;
      chk("t2_wren_tile_off", 32'(wren_tile_draw), 32'd0);
      chk("t2_wren_pixel_on", 32'(wren_pixel_draw), 32'd1);
      tick(41, 10);
      chk("t2_sprite_pulse_once", 32'(sprite_start), 32'd0);
      tile_wr = 1'b0;
      spr_wr = 1'b0;
      // 3: normal completion then swap
      tick(42, 10);
      sprite_done = 1'b1;
      tick(900, 10);
      chk("t3_state_done", 32'(status[3:2]), 32'd3);
      sprite_done = 1'b0;
      tick(1590, 10);
      chk("t3_switch", 32'(switch), 32'd1);
      chk("t3_state_idle", 32'(status[3:2]), 32'd0);
      chk("t3_no_overrun", 32'(status[1]), 32'd0);
      // 4: overrun when sprite never finishes
      tick(0, 11);
      for (int h = 100; h < 110; h++) tick(h, 11);
      tick(1590, 11);
      chk("t4_switch", 32'(switch), 32'd0);
      chk("t4_sticky", 32'(status[1]), 32'd1);
      chk("t4_count", 32'(status[15:8]), 32'd1);
      chk("t4_state", 32'(status[3:2]), 32'd0);
      tick(0, 12);
      chk("t4_restart", 32'(tile_start), 32'd1);
      chk("t4_line", 32'(render_line), 32'd13);
      // 5: frame wrap and non-render lines
      tick(1590, 12);
      tick(0, 524);
      chk("t5_wrap_start", 32'(tile_start), 32'd1);
      chk("t5_wrap_line", 32'(render_line), 32'd0);
      tick(1590, 524);
      sw_before = switch;
      tick(0, 480);
      chk("t5_no_start", 32'(tile_start), 32'd0);
      tick(1590, 480);
      chk("t5_no_swap", 32'(switch), 32'(sw_before));
      chk("t5_count", 32'(status[15:8]), 32'd3);
      // 6: async reset mid-tile, saturation, clear/set collision
      tick(1590, 5);
      tick(0, 5);
      tile_wr = 1'b1;
      reset = 1'b1;
      #1;
      chk("t6_rst_status", status, 32'd0);
      chk("t6_rst_wren", 32'(wren_tile_draw), 32'd0);
      chk("t6_rst_switch", 32'(switch), 32'd0);
      chk("t6_rst_start", 32'(tile_start), 32'd0);
      tile_wr = 1'b0;
      tick(7, 5);
      tick(7, 5);
      reset = 1'b0;
      for (int i = 0; i < 256; i++) tick(1590, 1);
      chk("t6_saturate", 32'(status[15:8]), 32'd255);
      clear_overrun = 1'b1;
      tick(1590, 1);
      chk("t6_clear_set_count", 32'(status[15:8]), 32'd1);
      chk("t6_clear_set_sticky", 32'(status[1]), 32'd1);
      tick(3, 1);
      chk("t6_clear_count", 32'(status[15:8]), 32'd0);
      clear_overrun = 1'b0;

      // Randomised lines, with edge vcounts favoured
      for (int ln = 0; ln < 80; ln++) begin
         int v;
         int n;
         case ($urandom_range(0, 5))
            0: v = 478;
            1: v = 524;
            2: v = 479;
            3: v = 523;
            default: v = int'($urandom_range(0, 524));
         endcase
         enable = ($urandom_range(0, 7) != 0);
         tick(0, v);
         n = int'($urandom_range(4, 30));
         for (int k = 0; k < n; k++) begin
            tile_done     = ($urandom_range(0, 3) == 0);
            sprite_done   = ($urandom_range(0, 3) == 0);
            tile_wr       = ($urandom_range(0, 1) == 0);
            spr_wr        = ($urandom_range(0, 1) == 0);
            clear_overrun = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            tick(int'($urandom_range(1, 1589)), v);
         end
         clear_overrun = ($urandom_range(0, 3) == 0);
         tick(1590, v);
         clear_overrun = 1'b0;
      end
      tick(3, 1);
      tick(3, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
